fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'd0, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, is the prefetch queue entries and the maximum outstanding imem requests; it is a power of two, at least 2.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  downstream IF/ID holding; do not dequeue.
REQ-006 redirect  in  1  taken branch or jump; flush and restart at redirect_pc.
REQ-007 redirect_pc  in  32  restart address, word-addressed.
REQ-008 imem_req  out  1  fetch request valid.
REQ-009 imem_addr  out  32  fetch address, word-addressed.
REQ-010 imem_ready  in  1  request accepted when imem_req and imem_ready are both high.
REQ-011 imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 inst_valid  out  1  inst_out and pc_out hold a valid instruction.
REQ-014 inst_out  out  32  head instruction; 32'd0 (NOP) when inst_valid is low.
REQ-015 pc_out  out  32  address of inst_out; 32'd0 when inst_valid is low.

Function
REQ-016 fetch_pc increments by 1 (word addressing, mod 2^32) on each accepted request; imem_addr = fetch_pc.
REQ-017 imem_req = !reset && !redirect && (queue_count + outstanding < DEPTH); the queue can therefore never overflow.
REQ-018 outstanding counter: +1 on accept, -1 on each imem_rvalid; both in the same cycle leave it unchanged.
REQ-019 resp_pc tracks the address of the next expected response and increments by 1 on each non-discarded response.
REQ-020 A non-discarded response enqueues {resp_pc, imem_rdata} and becomes visible on the outputs no earlier than the cycle after imem_rvalid (no bypass).
REQ-021 inst_valid = queue not empty; outputs show the head entry combinationally from queue state.
REQ-022 Dequeue occurs when inst_valid && !stall && !redirect; enqueue and dequeue in the same cycle are both allowed.
REQ-023 Redirect, in that cycle: queue emptied; fetch_pc <= redirect_pc; resp_pc <= redirect_pc; drop_count <= outstanding minus any response arriving that cycle.
REQ-024 Redirect priority: it overrides stall, dequeue and enqueue; a response arriving in the redirect cycle is discarded.
REQ-025 While drop_count > 0, each imem_rvalid decrements drop_count and the data is discarded; the queue and resp_pc are unchanged.
REQ-026 FSM states: RUN (drop_count = 0) and DRAIN (drop_count > 0).
REQ-027 FSM transitions: RUN->DRAIN on redirect with stale outstanding requests; DRAIN->RUN when the last stale response is dropped. New requests may issue in DRAIN within the REQ-017 limit.
REQ-028 A second redirect during DRAIN reloads drop_count per REQ-023.
REQ-029 imem_rvalid with outstanding = 0 is ignored, and the counters do not underflow.
REQ-030 Throughput: with single-cycle imem, imem_ready tied high and no stall, one instruction per cycle in steady state.

Reset
REQ-031 During reset: fetch_pc and resp_pc = RESET_PC; queue, outstanding and drop_count = 0; state RUN.
REQ-032 During reset: imem_req = 0, inst_valid = 0, inst_out = 0, pc_out = 0.
REQ-033 Reset asserted mid-operation discards all queued and in-flight state; responses to pre-reset requests that arrive after reset are ignored per REQ-029.

Structure
REQ-034 A shared package holds NOP_INST (32'd0), the default RESET_PC and the default DEPTH.
REQ-035 Queue storage is the sub-module fetch_fifo: synchronous, DEPTH x 64-bit {pc, inst}, with flush, push, pop, count, empty and full.

Verification
REQ-036 Reset release, 1-cycle imem, no stall -> requests at addresses 0,1,2,...; first inst_valid 2 cycles after reset drops with pc_out=0; one instruction per cycle thereafter.
REQ-037 stall held 5 cycles with imem_ready high -> at most DEPTH=4 entries plus outstanding requests; imem_req low at the limit; no instruction lost or duplicated after release.
REQ-038 redirect to 0x40 with 3 requests outstanding -> 3 responses discarded; next inst_valid has pc_out=0x40, inst = mem[0x40].
REQ-039 redirect in the same cycle as imem_rvalid and stall -> that response is dropped, the queue is empty next cycle, and fetch_pc=redirect_pc.
REQ-040 Back-to-back redirects 0x10 then 0x20 during DRAIN -> only 0x20, 0x21, ... reach the outputs.
REQ-041 imem_ready low for 3 cycles -> imem_addr held at the same value; fetch_pc=0xFFFFFFFF wraps to 0x00000000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the fetch unit.
// Queue entries carry the instruction together with its address.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'd0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam int          DEFAULT_DEPTH    = 4;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, inst} entries.
// Flush empties it in one cycle; push and pop may coincide.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents past the pointers are don't-care.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches, queues in-order
// responses and drops stale ones after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] q_count;
  logic [CW:0]   inflight;
  logic          accept;
  logic          rsp;
  logic          discard;
  logic          push;
  logic          pop;
  logic          q_empty;
  logic          q_full;
  fetch_entry_t  q_head;
  fetch_entry_t  q_in;

  assign inflight  = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req  = !reset && !redirect && !q_full
                   && (inflight < LIMIT);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;
  // A response with nothing in flight is noise.
  assign rsp       = imem_rvalid && (outstanding != '0);
  assign discard   = redirect || (state == DRAIN);
  assign push      = rsp && !discard;
  assign pop       = inst_valid && !stall && !redirect;
  assign q_in      = '{pc: resp_pc, inst: imem_rdata};

  assign inst_valid = !reset && !q_empty;
  assign inst_out   = inst_valid ? q_head.inst : NOP_INST;
  assign pc_out     = inst_valid ? q_head.pc : 32'd0;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push     (push),
    .push_data(q_in),
    .pop      (pop),
    .head     (q_head),
    .count    (q_count),
    .empty    (q_empty),
    .full     (q_full)
  );

  // Fetch and response address tracking plus in-flight count.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd1;
        if (push)   resp_pc  <= resp_pc + 32'd1;
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      drop_count <= '0;
    end else begin
      state      <= state_next;
      drop_count <= drop_next;
    end
  end

  // Drain FSM: count down stale responses left by a redirect.
  always_comb begin
    state_next = state;
    drop_next  = drop_count;
    unique case (state)
      RUN: begin
        if (redirect) begin
          drop_next = outstanding - CW'(rsp);
          if (drop_next != '0) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect) begin
          drop_next = outstanding - CW'(rsp);
          if (drop_next == '0) state_next = RUN;
        end else if (rsp) begin
          drop_next = drop_count - CW'(1);
          if (drop_next == '0) state_next = RUN;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem model with random latency and an
// expected-instruction-stream model of the fetch contract.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          cyc;
  int          total;
  int          bad;
  int          consumed;
  int          lat_min;
  int          lat_max;
  bit          spurious;
  logic [31:0] exp_pc;

  fetch_unit #(
    .RESET_PC(RPC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // One clock: drive imem response, check the stream, advance.
  task automatic cycle();
    bit got;
    got = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      got = 1;
    end else if (!reset && spurious && pend.size() == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (reset) begin
      pend.delete();
      exp_pc = RPC;
    end else begin
      total++;
      if (pend.size() > DEPTH) begin
        bad++;
        $display("FAIL outstanding_limit: got %0d want <=%0d",
                 pend.size(), DEPTH);
      end
      total++;
      if (inst_valid) begin
        if (!stall && !redirect) begin
          if (pc_out !== exp_pc || inst_out !== mem_word(exp_pc)) begin
            bad++;
            $display("FAIL stream: got pc=%h inst=%h want pc=%h inst=%h",
                     pc_out, inst_out, exp_pc, mem_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd1;
          consumed++;
        end
      end else if (pc_out !== 32'd0 || inst_out !== 32'd0) begin
        bad++;
        $display("FAIL nop_out: got pc=%h inst=%h want 0/0",
                 pc_out, inst_out);
      end
      if (redirect) exp_pc = redirect_pc;
      if (imem_req && imem_ready)
        pend.push_back('{imem_addr,
                         cyc + int'($urandom_range(lat_max, lat_min))});
      if (got) void'(pend.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    lat_min = 1;
    lat_max = 1;
    reset = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 ||
        inst_out !== 32'd0 || pc_out !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b v=%b i=%h p=%h want 0",
               imem_req, inst_valid, inst_out, pc_out);
    end
    cycle();
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== RPC + 32'(k)) begin
        bad++;
        $display("FAIL startup_req k=%0d: got req=%b addr=%h want 1/%h",
                 k, imem_req, imem_addr, RPC + 32'(k));
      end
      total++;
      if (inst_valid !== (k >= 2)) begin
        bad++;
        $display("FAIL startup_valid k=%0d: got %b want %b",
                 k, inst_valid, (k >= 2));
      end
      if (k >= 2) begin
        total++;
        if (pc_out !== RPC + 32'(k - 2)) begin
          bad++;
          $display("FAIL startup_pc k=%0d: got %h want %h",
                   k, pc_out, RPC + 32'(k - 2));
        end
      end
      cycle();
    end
    reset = 1'b1;
    #1;
    total++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL midop_reset: got v=%b req=%b want 0/0",
               inst_valid, imem_req);
    end
    cycle();
    reset = 1'b0;
    run(8);
  endtask

  task automatic test_stall();
    lat_min = 1;
    lat_max = 1;
    run(4);
    stall = 1'b1;
    run(4);
    #1;
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_limit: got req=%b v=%b want 0/1",
               imem_req, inst_valid);
    end
    cycle();
    stall = 1'b0;
    run(12);
  endtask

  task automatic test_redirect();
    int n;
    bit seen;
    do_reset();
    lat_min = 5;
    lat_max = 5;
    n = 0;
    while (pend.size() < 3 && n < 20) begin
      cycle();
      n++;
    end
    total++;
    if (pend.size() != 3) begin
      bad++;
      $display("FAIL redirect_setup: got %0d want 3", pend.size());
    end
    lat_min = 1;
    lat_max = 1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (inst_valid) begin
        seen = 1;
        total++;
        if (pc_out !== 32'h40 || inst_out !== mem_word(32'h40)) begin
          bad++;
          $display("FAIL redirect_first: got pc=%h inst=%h want 40/%h",
                   pc_out, inst_out, mem_word(32'h40));
        end
      end
      cycle();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL redirect_timeout: got none want pc=40");
    end
    run(6);
  endtask

  task automatic test_redirect_rvalid_stall();
    lat_min = 1;
    lat_max = 1;
    run(4);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    cycle();
    stall = 1'b0;
    redirect = 1'b0;
    #1;
    total++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h80) begin
      bad++;
      $display("FAIL redir_rv_stall: got v=%b addr=%h want 0/80",
               inst_valid, imem_addr);
    end
    run(8);
  endtask

  task automatic test_double_redirect();
    int n;
    int c0;
    bit seen;
    lat_min = 4;
    lat_max = 4;
    n = 0;
    while (pend.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    redirect = 1'b1;
    redirect_pc = 32'h10;
    cycle();
    redirect = 1'b0;
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'h20;
    cycle();
    redirect = 1'b0;
    lat_min = 1;
    lat_max = 1;
    c0 = consumed;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (inst_valid && !seen) begin
        seen = 1;
        total++;
        if (pc_out !== 32'h20) begin
          bad++;
          $display("FAIL double_redirect_first: got %h want 20", pc_out);
        end
      end
      cycle();
    end
    total++;
    if (consumed - c0 < 10) begin
      bad++;
      $display("FAIL double_redirect_flow: got %0d want >=10",
               consumed - c0);
    end
  endtask

  task automatic test_ready_wrap();
    lat_min = 1;
    lat_max = 1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    cycle();
    redirect = 1'b0;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFF) begin
        bad++;
        $display("FAIL ready_hold i=%0d: got req=%b addr=%h want 1/ffffffff",
                 i, imem_req, imem_addr);
      end
      cycle();
    end
    imem_ready = 1'b1;
    cycle();
    #1;
    total++;
    if (imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL wrap_addr: got %h want 00000000", imem_addr);
    end
    run(8);
  endtask

  task automatic test_spurious();
    int c0;
    imem_ready = 1'b0;
    run(8);
    spurious = 1'b1;
    run(3);
    spurious = 1'b0;
    #1;
    total++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL spurious: got v=%b req=%b want 0/1",
               inst_valid, imem_req);
    end
    imem_ready = 1'b1;
    c0 = consumed;
    run(10);
    total++;
    if (consumed - c0 < 6) begin
      bad++;
      $display("FAIL spurious_flow: got %0d want >=6", consumed - c0);
    end
  endtask

  task automatic test_random();
    int c0;
    c0 = consumed;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(99) < 30);
      imem_ready  = ($urandom_range(99) < 70);
      redirect    = ($urandom_range(99) < 3);
      redirect_pc = $urandom;
      reset       = ($urandom_range(999) < 5);
      cycle();
    end
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    imem_ready = 1'b1;
    run(10);
    total++;
    if (consumed - c0 < 500) begin
      bad++;
      $display("FAIL random_flow: got %0d want >=500", consumed - c0);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    consumed = 0;
    cyc = 0;
    spurious = 0;
    lat_min = 1;
    lat_max = 1;
    exp_pc = RPC;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    imem_ready = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_rvalid_stall();
    test_double_redirect();
    test_ready_wrap();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
